// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C master: host command codes, FSM states and
// quarter-phase indices within one SCL bit period.
package i2c_pkg;

    localparam logic [1:0] I2C_CMD_START = 2'd0;
    localparam logic [1:0] I2C_CMD_WRITE = 2'd1;
    localparam logic [1:0] I2C_CMD_READ  = 2'd2;
    localparam logic [1:0] I2C_CMD_STOP  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } i2c_state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // SCL is released for the middle two quarters of every data/ack/start bit.
    function automatic logic scl_high(input logic [1:0] q);
        return (q == Q1) || (q == Q2);
    endfunction

endpackage

// File: rtl/i2c_master_tick.sv
// Quarter-bit tick generator: one tick every CLK_DIV cycles, restartable on
// command acceptance and freezable on the last cycle of a quarter.
module i2c_master_tick #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic freeze,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_reg;
    logic       at_last;

    assign at_last = (cnt_reg == LAST);
    assign tick    = at_last & ~freeze;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= 8'd0;
        end else if (restart) begin
            cnt_reg <= 8'd0;
        end else if (at_last) begin
            // While frozen the counter parks on its last value so the quarter
            // ends on the first cycle the freeze is lifted.
            if (!freeze) begin
                cnt_reg <= 8'd0;
            end
        end else begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pad input, with one extra history
// flop providing single-cycle rise/fall pulses on the synchronized level.
module sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] pipe_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_reg <= {3{RESET_VAL}};
        end else begin
            pipe_reg <= {pipe_reg[1:0], d};
        end
    end

    assign q    = pipe_reg[1];
    assign rise = pipe_reg[1] & ~pipe_reg[2];
    assign fall = ~pipe_reg[1] & pipe_reg[2];

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C master: START/WRITE/READ/STOP commands in, one response per byte out.
// Define I2C_MASTER_STRETCH_EN to honour target clock stretching during the SCL high phase.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda,
    output logic       scl_out,
    output logic       sda_out,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       busy
);

    i2c_state_t state_reg, state_next;
    logic [1:0] q_reg, q_next;
    logic [2:0] bit_reg, bit_next;
    logic [7:0] shift_reg, shift_next;
    logic       sample_reg, sample_next;
    logic [1:0] op_reg, op_next;
    logic       nack_cmd_reg, nack_cmd_next;
    logic       busy_reg, busy_next;
    logic       ready_reg, ready_next;
    logic       rsp_valid_reg, rsp_valid_next;
    logic [7:0] rsp_data_reg, rsp_data_next;
    logic       rsp_nack_reg, rsp_nack_next;
    logic       scl_reg, scl_next;
    logic       sda_reg, sda_next;

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;
    logic accept, tick, freeze;

    sync_edge u_scl_sync (
        .clk(clk), .rst(rst), .d(scl), .q(scl_s), .rise(scl_rise), .fall(scl_fall)
    );
    sync_edge u_sda_sync (
        .clk(clk), .rst(rst), .d(sda), .q(sda_s), .rise(sda_rise), .fall(sda_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{scl_s, scl_rise, scl_fall, sda_rise, sda_fall};

    assign accept = cmd_valid & ready_reg;

`ifdef I2C_MASTER_STRETCH_EN
    // Hold the end of Q1 until the bus really shows SCL high.
    assign freeze = (state_reg != ST_IDLE) && (q_reg == Q1) && !scl_s;
`else
    assign freeze = 1'b0;
`endif

    i2c_master_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk), .rst(rst), .restart(accept), .freeze(freeze), .tick(tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            q_reg         <= Q0;
            bit_reg       <= 3'd0;
            shift_reg     <= 8'd0;
            sample_reg    <= 1'b1;
            op_reg        <= I2C_CMD_START;
            nack_cmd_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 8'd0;
            rsp_nack_reg  <= 1'b0;
            scl_reg       <= 1'b1;
            sda_reg       <= 1'b1;
        end else begin
            state_reg     <= state_next;
            q_reg         <= q_next;
            bit_reg       <= bit_next;
            shift_reg     <= shift_next;
            sample_reg    <= sample_next;
            op_reg        <= op_next;
            nack_cmd_reg  <= nack_cmd_next;
            busy_reg      <= busy_next;
            ready_reg     <= ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_nack_reg  <= rsp_nack_next;
            scl_reg       <= scl_next;
            sda_reg       <= sda_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        q_next         = q_reg;
        bit_next       = bit_reg;
        shift_next     = shift_reg;
        sample_next    = sample_reg;
        op_next        = op_reg;
        nack_cmd_next  = nack_cmd_reg;
        busy_next      = busy_reg;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_reg;
        rsp_nack_next  = rsp_nack_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    op_next       = cmd;
                    shift_next    = cmd_data;
                    nack_cmd_next = cmd_nack;
                    bit_next      = 3'd0;
                    case (cmd)
                        I2C_CMD_START: begin
                            // From a free bus the first two quarters are already satisfied.
                            state_next = ST_START;
                            q_next     = busy_reg ? Q0 : Q2;
                            busy_next  = 1'b1;
                        end
                        I2C_CMD_STOP: begin
                            if (busy_reg) begin
                                state_next = ST_STOP;
                                q_next     = Q0;
                            end
                        end
                        default: begin
                            if (busy_reg) begin
                                state_next = ST_BIT;
                                q_next     = Q0;
                            end
                        end
                    endcase
                end
            end
            ST_START: begin
                if (tick) begin
                    q_next = q_reg + 2'd1;
                    if (q_reg == Q3) begin
                        state_next = ST_BIT;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    q_next = q_reg + 2'd1;
                    if (q_reg == Q2) begin
                        sample_next = sda_s;
                    end
                    // Shift only once SCL is low again so SDA never moves while SCL is high.
                    if (q_reg == Q3) begin
                        shift_next = {shift_reg[6:0], sample_reg};
                        bit_next   = bit_reg + 3'd1;
                        if (bit_reg == 3'd7) begin
                            state_next = ST_ACK;
                        end
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    q_next = q_reg + 2'd1;
                    if (q_reg == Q2) begin
                        sample_next = sda_s;
                    end
                    if (q_reg == Q3) begin
                        state_next     = ST_IDLE;
                        rsp_valid_next = 1'b1;
                        rsp_data_next  = (op_reg == I2C_CMD_READ) ? shift_reg : 8'h00;
                        rsp_nack_next  = (op_reg == I2C_CMD_READ) ? 1'b0 : sample_reg;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    q_next = q_reg + 2'd1;
                    if (q_reg == Q3) begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        ready_next = (state_next == ST_IDLE);

        // Pad levels are registered from the next-state view so they change in
        // lockstep with the phase they belong to.
        scl_next = 1'b1;
        sda_next = 1'b1;
        case (state_next)
            ST_IDLE: begin
                scl_next = ~busy_next;
            end
            ST_START: begin
                scl_next = scl_high(q_next);
                sda_next = (q_next == Q0) || (q_next == Q1);
            end
            ST_BIT: begin
                scl_next = scl_high(q_next);
                sda_next = (op_next == I2C_CMD_READ) | shift_next[7];
            end
            ST_ACK: begin
                scl_next = scl_high(q_next);
                sda_next = (op_next == I2C_CMD_READ) ? nack_cmd_next : 1'b1;
            end
            ST_STOP: begin
                scl_next = (q_next != Q0);
                sda_next = (q_next == Q2) || (q_next == Q3);
            end
            default: begin
                scl_next = 1'b1;
                sda_next = 1'b1;
            end
        endcase
    end

    assign scl_out   = scl_reg;
    assign sda_out   = sda_reg;
    assign cmd_ready = ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_nack  = rsp_nack_reg;
    assign busy      = busy_reg;

endmodule
